reserv_station: RTL
===================

# reserv_station

Parametrised, age-ordered reservation station for the execute stage; one instance sits in front of each functional unit (ALU, forwarder, jump, branch). It accepts dispatched instructions with up to NOPS renamed operands, snoops CDB_N ROB broadcast ports to wake waiting operands, and issues the oldest fully-ready entry to its unit over a valid/ready handshake. It adds configurable depth, operand and broadcast-port counts, a side payload, back-pressure, flush and overflow detection.

## Interface
- DEPTH, 4: number of entries (≥2)
- NOPS, 2: source operands per entry (1..3)
- DATA_W, 32: operand/result width
- TAG_W, 4: ROB tag width; tag value all-ones (TAG_INVALID) means "no tag / operand ready"
- OP_W, 4: opcode width
- EXTRA_W, 64: opaque side payload (e.g. {pc_addr, offset}), passed through unchanged
- CDB_N, 2: number of broadcast ports snooped
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous: discard all entries
- in_ce  in  1  dispatch strobe
- in_target  in  TAG_W  destination tag; entry accepted only when in_ce=1 and in_target≠TAG_INVALID
- in_op  in  OP_W  opcode
- in_val  in  NOPS*DATA_W  operand values, operand i at bits [i*DATA_W +: DATA_W]
- in_tag  in  NOPS*TAG_W  operand tags; TAG_INVALID = value already valid
- in_extra  in  EXTRA_W  side payload
- cdb_tag  in  CDB_N*TAG_W  broadcast tags; port inactive when TAG_INVALID
- cdb_val  in  CDB_N*DATA_W  broadcast values
- full  out  1  registered; count==DEPTH
- count  out  $clog2(DEPTH+1)  occupied entries
- overflow  out  1  sticky: dispatch attempted while full
- iss_valid  out  1  an entry is ready to issue
- iss_ready  in  1  functional unit accepts
- iss_target / iss_op / iss_val / iss_extra  out  TAG_W / OP_W / NOPS*DATA_W / EXTRA_W  issued entry fields

## Operation
- Storage is a collapsing queue: index 0 oldest; valid entries always contiguous from 0.
- Per entry: target, op, extra, and per operand {tag, val}; operand ready when tag==TAG_INVALID.
- Wakeup: every cycle, each waiting operand compares its tag with all active cdb_tag ports; on match it captures cdb_val and sets tag to TAG_INVALID. Multiple matching ports: lowest port index wins.
- Dispatch bypass: an incoming operand whose in_tag matches an active CDB port in the same cycle is stored already ready with the CDB value.
- Select: lowest-index entry with all NOPS operands ready. iss_* driven combinationally from that entry's registered state only; iss_valid = any ready entry & !flush. iss_valid never depends on iss_ready.
- Issue fire = iss_valid & iss_ready: selected entry removed; younger entries shift down by one, keeping order and applying same-cycle wakeup.
- Dispatch while !full: appended at index count (count−1 if same-cycle fire). Dispatch while full: dropped, overflow set; holds even if an issue fires that cycle.
- count next = count + accept − fire; full = (count next == DEPTH), registered.
- flush: next edge all entries invalid, count=0, full=0; same-cycle dispatch and issue ignored. overflow not cleared by flush.
- Outputs when iss_valid=0: iss_target=TAG_INVALID, other iss_* fields 0.

## Timing
- Reset (async assert, any cycle, mid-operation included): all entries invalid, count=0, full=0, overflow=0, iss_valid=0, iss_target=TAG_INVALID, iss_op/val/extra=0.
- Dispatch at edge t with all operands ready → iss_valid=1 in cycle t+1 (1-cycle latency).
- Last operand broadcast in cycle t → entry captures at edge t+1, iss_valid in cycle t+1.
- Stall: while iss_valid=1 and iss_ready=0, iss_* stable unless an older entry becomes ready (older always preempts).
- Full throughput: one dispatch and one issue per cycle sustained.

## Test plan
- Reset then dispatch target=3, op=2, tags {F,F}, vals {10,20}, iss_ready=1 → next cycle iss_valid=1, iss_target=3, iss_val={10,20}; following cycle iss_valid=0, count=0.
- Dispatch target=1 waiting tag 5, then target=2 ready; CDB port1 tag=5 val=0x55 two cycles later → target 2 issues first; target 1 issues cycle after broadcast with operand 0x55.
- Bypass: dispatch operand tag=7 while cdb port0 tag=7 val=0xAB → entry issues next cycle with 0xAB.
- Fill DEPTH=4 with iss_ready=0 → full=1, count=4; fifth dispatch → overflow=1, count stays 4; iss_ready=1 drains in dispatch order 0..3.
- Simultaneous dispatch and fire at count=2 → count stays 2, order preserved; both CDB ports carrying tag 4 with 0x11/0x22 → operand gets 0x11.
- flush with 3 entries and concurrent dispatch → next cycle count=0, full=0, iss_valid=0; async rst mid-drain → all outputs at reset values immediately.

Source files
------------

// File: rtl/reserv_station_if.sv
// Dispatch, CDB snoop, status and issue signals of one reservation station.
// master = dispatcher/functional-unit side, slave = the station itself.
interface reserv_station_if #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned NOPS    = 2,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned OP_W    = 4,
    parameter int unsigned EXTRA_W = 64,
    parameter int unsigned CDB_N   = 2
);
    logic                         flush;
    logic                         in_ce;
    logic [TAG_W-1:0]             in_target;
    logic [OP_W-1:0]              in_op;
    logic [NOPS*DATA_W-1:0]       in_val;
    logic [NOPS*TAG_W-1:0]        in_tag;
    logic [EXTRA_W-1:0]           in_extra;
    logic [CDB_N*TAG_W-1:0]       cdb_tag;
    logic [CDB_N*DATA_W-1:0]      cdb_val;
    logic                         full;
    logic [$clog2(DEPTH+1)-1:0]   count;
    logic                         overflow;
    logic                         iss_valid;
    logic                         iss_ready;
    logic [TAG_W-1:0]             iss_target;
    logic [OP_W-1:0]              iss_op;
    logic [NOPS*DATA_W-1:0]       iss_val;
    logic [EXTRA_W-1:0]           iss_extra;

    modport master (
        output flush, in_ce, in_target, in_op, in_val, in_tag, in_extra,
               cdb_tag, cdb_val, iss_ready,
        input  full, count, overflow, iss_valid, iss_target, iss_op, iss_val, iss_extra
    );

    modport slave (
        input  flush, in_ce, in_target, in_op, in_val, in_tag, in_extra,
               cdb_tag, cdb_val, iss_ready,
        output full, count, overflow, iss_valid, iss_target, iss_op, iss_val, iss_extra
    );
endinterface

// File: rtl/reserv_station.sv
// Age-ordered reservation station: collapsing queue (index 0 oldest) with CDB wakeup,
// dispatch bypass and oldest-ready selection feeding one functional unit.
module reserv_station #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned NOPS    = 2,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned OP_W    = 4,
    parameter int unsigned EXTRA_W = 64,
    parameter int unsigned CDB_N   = 2
) (
    input logic             clk,
    input logic             rst,
    reserv_station_if.slave bus
);
    localparam int unsigned      CW          = $clog2(DEPTH + 1);
    localparam int unsigned      IW          = $clog2(DEPTH);
    localparam logic [TAG_W-1:0] TAG_INVALID = '1;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] val;
    } opnd_t;

    typedef struct packed {
        logic [TAG_W-1:0]   target;
        logic [OP_W-1:0]    op;
        logic [EXTRA_W-1:0] extra;
        opnd_t [NOPS-1:0]   ops;
    } entry_t;

    entry_t           ent_q [DEPTH];
    entry_t           ent_d [DEPTH];
    entry_t           woke  [DEPTH];
    entry_t           nent;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic [CW-1:0]    pos;
    logic             full_q;
    logic             ovf_q;
    logic [DEPTH-1:0] rdy;
    logic [IW-1:0]    sel;
    logic             any_rdy;
    logic             fire;
    logic             attempt;
    logic             accept;

    function automatic opnd_t snoop(input opnd_t o,
                                    input logic [CDB_N*TAG_W-1:0]  ctag,
                                    input logic [CDB_N*DATA_W-1:0] cval);
        opnd_t r;
        r = o;
        // Scan high to low so the lowest matching port is the last writer.
        for (int unsigned p = CDB_N; p > 0; p--) begin
            if (o.tag != TAG_INVALID && ctag[(p-1)*TAG_W +: TAG_W] == o.tag) begin
                r.tag = TAG_INVALID;
                r.val = cval[(p-1)*DATA_W +: DATA_W];
            end
        end
        return r;
    endfunction

    always_comb begin
        rdy     = '0;
        sel     = '0;
        any_rdy = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            rdy[i] = (CW'(i) < count_q);
            for (int unsigned k = 0; k < NOPS; k++)
                if (ent_q[i].ops[k].tag != TAG_INVALID) rdy[i] = 1'b0;
            if (rdy[i] && !any_rdy) begin
                sel     = IW'(i);
                any_rdy = 1'b1;
            end
        end
    end

    assign bus.iss_valid = any_rdy & ~bus.flush;
    assign fire          = bus.iss_valid & bus.iss_ready;
    assign attempt       = bus.in_ce & (bus.in_target != TAG_INVALID) & ~bus.flush;
    assign accept        = attempt & ~full_q;

    always_comb begin
        bus.iss_target = TAG_INVALID;
        bus.iss_op     = '0;
        bus.iss_val    = '0;
        bus.iss_extra  = '0;
        if (bus.iss_valid) begin
            bus.iss_target = ent_q[sel].target;
            bus.iss_op     = ent_q[sel].op;
            bus.iss_extra  = ent_q[sel].extra;
            for (int unsigned k = 0; k < NOPS; k++)
                bus.iss_val[k*DATA_W +: DATA_W] = ent_q[sel].ops[k].val;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            woke[i] = ent_q[i];
            for (int unsigned k = 0; k < NOPS; k++)
                woke[i].ops[k] = snoop(ent_q[i].ops[k], bus.cdb_tag, bus.cdb_val);
        end
    end

    always_comb begin
        nent        = '0;
        nent.target = bus.in_target;
        nent.op     = bus.in_op;
        nent.extra  = bus.in_extra;
        for (int unsigned k = 0; k < NOPS; k++)
            nent.ops[k] = snoop({bus.in_tag[k*TAG_W +: TAG_W], bus.in_val[k*DATA_W +: DATA_W]},
                                bus.cdb_tag, bus.cdb_val);

        pos     = fire ? count_q - CW'(1) : count_q;
        count_d = bus.flush ? '0 : count_q + CW'(accept) - CW'(fire);

        // Entries at or above the issued slot collapse down by one; slots past count are don't-care.
        for (int unsigned i = 0; i < DEPTH; i++)
            ent_d[i] = woke[i];
        for (int unsigned i = 0; i < DEPTH - 1; i++)
            if (fire && IW'(i) >= sel) ent_d[i] = woke[i+1];
        for (int unsigned i = 0; i < DEPTH; i++)
            if (accept && CW'(i) == pos) ent_d[i] = nent;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++)
                ent_q[i] <= '0;
        end else begin
            count_q <= count_d;
            full_q  <= (count_d == CW'(DEPTH));
            ovf_q   <= ovf_q | (attempt & full_q);
            for (int unsigned i = 0; i < DEPTH; i++)
                ent_q[i] <= ent_d[i];
        end
    end

    assign bus.count    = count_q;
    assign bus.full     = full_q;
    assign bus.overflow = ovf_q;
endmodule
